// File: rtl/freq_generator.sv
// CSR-programmable square-wave generator: gen_clk period is 2*(HALF_PERIOD+1) clk cycles.
// Define FREQ_GENERATOR_BURST_EN to add BURST_LEN and CTRL.BURST (stop after N rising edges).
module freq_generator #(
  parameter logic [31:0] DEFAULT_HALF_PERIOD = 32'd24,
  parameter logic [31:0] VERSION             = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic        gen_clk,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic [31:0] half_period_q, half_period_d;
  logic [31:0] edge_count_q, edge_count_d;
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] rdata;
  logic        gen_clk_q;
  logic        wr_ctrl, wr_half;
  logic        phase_end;
  logic        burst_hit;
  logic        burst_bit;

  assign wr_ctrl   = csr_write && (csr_address == 4'd0);
  assign wr_half   = csr_write && (csr_address == 4'd1);
  assign phase_end = (phase_cnt_q == shadow_q);

`ifdef FREQ_GENERATOR_BURST_EN
  logic        burst_q, burst_d;
  logic [31:0] burst_len_q, burst_len_d;
  logic        wr_burst_len;

  assign wr_burst_len = csr_write && (csr_address == 4'd4);
  assign burst_bit    = burst_q;
  // Edge count already includes the rising edge of the HIGH phase now ending.
  assign burst_hit    = burst_q && (burst_len_q != 32'd0) && (edge_count_q == burst_len_q);

  always_comb begin
    burst_d     = burst_q;
    burst_len_d = burst_len_q;
    if (wr_ctrl) burst_d = csr_writedata[1];
    if (wr_burst_len) burst_len_d = csr_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q     <= 1'b0;
      burst_len_q <= 32'd0;
    end else begin
      burst_q     <= burst_d;
      burst_len_q <= burst_len_d;
    end
  end
`else
  assign burst_bit = 1'b0;
  assign burst_hit = 1'b0;
`endif

  always_comb begin
    enable_d      = enable_q;
    half_period_d = half_period_q;
    if (wr_ctrl) enable_d = csr_writedata[0];
    if (wr_half) half_period_d = csr_writedata;
  end

  // Reloads sample half_period_q, so a write landing on a boundary applies one phase later.
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    shadow_d     = shadow_q;
    edge_count_d = edge_count_q;
    unique case (state_q)
      StIdle: begin
        if (enable_d) begin
          state_d      = StLow;
          phase_cnt_d  = 32'd0;
          shadow_d     = half_period_q;
          edge_count_d = 32'd0;
        end
      end
      StLow: begin
        if (phase_end) begin
          state_d      = StHigh;
          phase_cnt_d  = 32'd0;
          shadow_d     = half_period_q;
          edge_count_d = edge_count_q + 32'd1;
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          state_d     = burst_hit ? StDone : StLow;
          phase_cnt_d = 32'd0;
          shadow_d    = half_period_q;
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      StDone: begin
        phase_cnt_d = 32'd0;
      end
      default: begin
        state_d     = StIdle;
        phase_cnt_d = 32'd0;
      end
    endcase
    // Disabling wins in every state, including mid-phase.
    if (!enable_d) begin
      state_d     = StIdle;
      phase_cnt_d = 32'd0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (csr_address)
      4'd0:    rdata = {30'd0, burst_bit, enable_q};
      4'd1:    rdata = half_period_q;
      4'd2:    rdata = edge_count_q;
      4'd3:    rdata = VERSION;
`ifdef FREQ_GENERATOR_BURST_EN
      4'd4:    rdata = burst_len_q;
`endif
      default: rdata = 32'd0;
    endcase
    readdata_d = csr_read ? rdata : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      enable_q      <= 1'b0;
      half_period_q <= DEFAULT_HALF_PERIOD;
      edge_count_q  <= 32'd0;
      phase_cnt_q   <= 32'd0;
      shadow_q      <= DEFAULT_HALF_PERIOD;
      readdata_q    <= 32'd0;
      gen_clk_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      half_period_q <= half_period_d;
      edge_count_q  <= edge_count_d;
      phase_cnt_q   <= phase_cnt_d;
      shadow_q      <= shadow_d;
      readdata_q    <= readdata_d;
      gen_clk_q     <= (state_d == StHigh);
    end
  end

  assign csr_readdata = readdata_q;
  assign gen_clk      = gen_clk_q;
  assign busy         = (state_q != StIdle);

endmodule
